// File: rtl/piece_queue.sv
// Piece queue: LFSR-fed tetromino generator with head + preview window.
// Define SEVEN_BAG_EN to draw pieces from a 7-bag instead of raw LFSR bits.
module piece_queue #(
    parameter logic [31:0] LFSR_SEED     = 32'h12345678,
    parameter int          PREVIEW_DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         take,
    input  logic                         seed_load,
    input  logic [31:0]                  seed_in,
    output logic                         head_valid,
    output logic [2:0]                   head_type,
    output logic [15:0]                  next_block_shape,
    output logic [16*PREVIEW_DEPTH-1:0]  preview_shapes,
    output logic                         queue_full
);

    localparam int             D    = PREVIEW_DEPTH + 1;
    localparam int             CW   = $clog2(D + 1);
    localparam logic [CW-1:0]  DC   = CW'(D);
    localparam logic [31:0]    TAPS = 32'h80200003;

    function automatic logic [15:0] shape_of(input logic [2:0] t);
        case (t)
            3'd0:    shape_of = 16'h0660;
            3'd1:    shape_of = 16'h0f00;
            3'd2:    shape_of = 16'h0360;
            3'd3:    shape_of = 16'h0630;
            3'd4:    shape_of = 16'h0740;
            3'd5:    shape_of = 16'h0e20;
            3'd6:    shape_of = 16'h0720;
            default: shape_of = 16'h0000;
        endcase
    endfunction

    logic [31:0]   r_lfsr;
    logic [CW-1:0] r_count;
    logic [2:0]    r_q [D];

    logic [2:0]    w_cand;
    logic          w_take_acc;
    logic          w_elig;
    logic          w_push;
    logic [2:0]    w_piece;
    logic [CW-1:0] w_wr_idx;
    logic [CW-1:0] w_count_nxt;
    logic [2:0]    w_q_nxt [D];
    logic [31:0]   w_lfsr_step;
    logic          w_hv_nxt;
    logic [2:0]    w_ht_nxt;
    logic [16*PREVIEW_DEPTH-1:0] w_prev_nxt;

    assign w_cand      = r_lfsr[2:0];
    assign w_take_acc  = take && (r_count != '0);
    assign w_elig      = (r_count < DC) || w_take_acc;
    assign w_wr_idx    = r_count - CW'(w_take_acc);
    assign w_lfsr_step = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? TAPS : 32'h0);

`ifdef SEVEN_BAG_EN
    logic [6:0] r_mask;
    logic [6:0] w_mask_set;
    logic [6:0] w_mask_nxt;
    logic [2:0] w_start;
    logic [3:0] w_j;
    logic       w_found;

    // First unused type at or above the candidate, wrapping 6 -> 0.
    always_comb begin
        w_start = (w_cand == 3'd7) ? 3'd0 : w_cand;
        w_found = 1'b0;
        w_piece = 3'd0;
        w_j     = 4'd0;
        for (int k = 0; k < 7; k++) begin
            w_j = {1'b0, w_start} + 4'(k);
            if (w_j >= 4'd7) w_j = w_j - 4'd7;
            if (!w_found && !r_mask[w_j[2:0]]) begin
                w_found = 1'b1;
                w_piece = w_j[2:0];
            end
        end
        w_push     = w_elig;
        w_mask_set = r_mask | (7'd1 << w_piece);
        w_mask_nxt = r_mask;
        if (w_push) w_mask_nxt = (w_mask_set == 7'h7f) ? 7'h00 : w_mask_set;
    end

    always_ff @(posedge clk) begin
        if (rst || seed_load) r_mask <= 7'h00;
        else                  r_mask <= w_mask_nxt;
    end
`else
    assign w_piece = w_cand;
    assign w_push  = w_elig && (w_cand != 3'd7);
`endif

    always_comb begin
        for (int i = 0; i < D; i++) w_q_nxt[i] = r_q[i];
        if (w_take_acc) begin
            for (int i = 0; i < D - 1; i++) w_q_nxt[i] = r_q[i+1];
            w_q_nxt[D-1] = 3'd0;
        end
        for (int i = 0; i < D; i++)
            if (w_push && (w_wr_idx == CW'(i))) w_q_nxt[i] = w_piece;
        w_count_nxt = w_wr_idx + CW'(w_push);
    end

    // Outputs are computed from next state so they register on the same edge.
    always_comb begin
        w_hv_nxt   = (w_count_nxt != '0);
        w_ht_nxt   = w_hv_nxt ? w_q_nxt[0] : 3'd0;
        w_prev_nxt = '0;
        for (int i = 0; i < PREVIEW_DEPTH; i++)
            if (w_count_nxt > CW'(i + 1))
                w_prev_nxt[16*i +: 16] = shape_of(w_q_nxt[i+1]);
    end

    always_ff @(posedge clk) begin
        if (rst || seed_load) begin
            if (rst)                  r_lfsr <= LFSR_SEED;
            else if (seed_in == '0)   r_lfsr <= LFSR_SEED;
            else                      r_lfsr <= seed_in;
            r_count          <= '0;
            for (int i = 0; i < D; i++) r_q[i] <= 3'd0;
            head_valid       <= 1'b0;
            head_type        <= 3'd0;
            next_block_shape <= 16'h0;
            preview_shapes   <= '0;
            queue_full       <= 1'b0;
        end else begin
            r_lfsr           <= w_lfsr_step;
            r_count          <= w_count_nxt;
            r_q              <= w_q_nxt;
            head_valid       <= w_hv_nxt;
            head_type        <= w_ht_nxt;
            next_block_shape <= w_hv_nxt ? shape_of(w_q_nxt[0]) : 16'h0;
            preview_shapes   <= w_prev_nxt;
            queue_full       <= (w_count_nxt == DC);
        end
    end

endmodule

// File: tb/tb_piece_queue.sv
// Bench for piece_queue: queue-based reference model plus directed pins.
// Honours SEVEN_BAG_EN the same way the design does.
module tb_piece_queue;

    localparam int PD = 3;
    localparam int D  = PD + 1;
    localparam logic [31:0] SEED = 32'h12345678;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             take = 1'b0;
    logic             seed_load = 1'b0;
    logic [31:0]      seed_in = 32'h0;
    logic             head_valid;
    logic [2:0]       head_type;
    logic [15:0]      next_block_shape;
    logic [16*PD-1:0] preview_shapes;
    logic             queue_full;

    piece_queue #(.LFSR_SEED(SEED), .PREVIEW_DEPTH(PD)) dut (
        .clk(clk), .rst(rst), .take(take), .seed_load(seed_load),
        .seed_in(seed_in), .head_valid(head_valid), .head_type(head_type),
        .next_block_shape(next_block_shape),
        .preview_shapes(preview_shapes), .queue_full(queue_full)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int          mq[$];
    logic [31:0] mlfsr;
    logic [6:0]  mmask;

    function automatic logic [15:0] shp(input int t);
        logic [15:0] tbl [7];
        tbl = '{16'h0660, 16'h0f00, 16'h0360, 16'h0630,
                16'h0740, 16'h0e20, 16'h0720};
        return tbl[t];
    endfunction

    task automatic chk(input string nm, input logic [47:0] got,
                       input logic [47:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic m_step(input bit r, input bit sl, input logic [31:0] si,
                          input bit tk);
        int cand;
        int s;
        int t;
        bit found;
        if (r) begin
            mlfsr = SEED; mq.delete(); mmask = '0;
        end else if (sl) begin
            mlfsr = (si == 0) ? SEED : si; mq.delete(); mmask = '0;
        end else begin
            cand = int'(mlfsr[2:0]);
            if (tk && mq.size() > 0) void'(mq.pop_front());
            if (mq.size() < D) begin
`ifdef SEVEN_BAG_EN
                s = (cand == 7) ? 0 : cand;
                found = 0;
                for (int k = 0; k < 7; k++) begin
                    t = (s + k) % 7;
                    if (!found && !mmask[t]) begin
                        found = 1;
                        mq.push_back(t);
                        mmask[t] = 1'b1;
                    end
                end
                if (mmask == 7'h7f) mmask = '0;
`else
                s = 0; t = 0; found = 0;
                if (cand != 7) mq.push_back(cand);
`endif
            end
            mlfsr = (mlfsr >> 1) ^ (mlfsr[0] ? 32'h80200003 : 32'h0);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [47:0] ep;
            ep = '0;
            for (int i = 0; i < PD; i++)
                if (mq.size() > i + 1) ep[16*i +: 16] = shp(mq[i+1]);
            chk("head_valid", 48'(head_valid), 48'(mq.size() > 0));
            chk("head_type", 48'(head_type),
                48'(mq.size() > 0 ? mq[0] : 0));
            chk("next_shape", 48'(next_block_shape),
                48'(mq.size() > 0 ? shp(mq[0]) : 16'h0));
            chk("preview", 48'(preview_shapes), ep);
            chk("queue_full", 48'(queue_full), 48'(mq.size() == D));
        end
    end

    task automatic cyc(input bit r, input bit sl, input logic [31:0] si,
                       input bit tk);
        rst = r; seed_load = sl; seed_in = si; take = tk;
        @(posedge clk);
        m_step(r, sl, si, tk);
        chk_en = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_hv"}, 48'(head_valid), 48'd0);
        chk({nm, "_ht"}, 48'(head_type), 48'd0);
        chk({nm, "_shape"}, 48'(next_block_shape), 48'd0);
        chk({nm, "_prev"}, 48'(preview_shapes), 48'd0);
        chk({nm, "_full"}, 48'(queue_full), 48'd0);
    endtask

    // Seed 0x12345678 gives candidates 0,4,6,7,4,...
    task automatic fill_pins(input string nm);
        cyc(0, 0, 0, 1);
        chk({nm, "_f1_hv"}, 48'(head_valid), 48'd1);
        chk({nm, "_f1_ht"}, 48'(head_type), 48'd0);
        chk({nm, "_f1_shape"}, 48'(next_block_shape), 48'h0660);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk({nm, "_f3_prev"}, 48'(preview_shapes), 48'h0000_0720_0740);
        cyc(0, 0, 0, 0);
`ifdef SEVEN_BAG_EN
        chk({nm, "_f4_full"}, 48'(queue_full), 48'd1);
        chk({nm, "_f4_prev"}, 48'(preview_shapes), 48'h0f00_0720_0740);
`else
        chk({nm, "_f4_full"}, 48'(queue_full), 48'd0);
        cyc(0, 0, 0, 0);
        chk({nm, "_f5_full"}, 48'(queue_full), 48'd1);
        chk({nm, "_f5_prev"}, 48'(preview_shapes), 48'h0740_0720_0740);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] got [14];
        logic [7:0] m;

        cyc(1, 0, 0, 0);
        chk_zero("reset");
        fill_pins("reset");

        for (int c = 0; c < 3000; c++) begin
            bit r, sl, tk;
            logic [31:0] si;
            r  = ($urandom % 100) == 0;
            sl = ($urandom % 50) == 0;
            si = ($urandom % 2) ? $urandom : 32'h0;
            tk = ($urandom % 2) == 1;
            cyc(r, sl, si, tk);
        end

        cyc(0, 1, 0, 1);
        chk_zero("seedld");
        fill_pins("seedld");

`ifdef SEVEN_BAG_EN
        for (int p = 0; p < 14; p++) begin
            got[p] = head_type;
            cyc(0, 0, 0, 1);
            cyc(0, 0, 0, 0);
        end
        for (int g = 0; g < 2; g++) begin
            m = '0;
            for (int k = 0; k < 7; k++) m[got[g*7+k]] = 1'b1;
            chk("bag_perm", 48'(m), 48'h7f);
        end
        for (int c = 0; c < 20; c++) begin
            cyc(0, 0, 0, 1);
            chk("held_take", 48'({head_valid, queue_full}), 48'b11);
        end
`else
        got[0] = '0; m = '0;
        for (int c = 0; c < 20; c++) cyc(0, 0, 0, 1);
`endif

        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("pre_rst_hv", 48'(head_valid), 48'd1);
        cyc(1, 0, 0, 1);
        chk_zero("midrst");
        fill_pins("midrst");

        for (int c = 0; c < 200; c++) cyc(0, 0, 0, ($urandom % 3) != 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/piece_queue.md
PIECE_QUEUE -- requirements
Module: piece_queue

Interface
REQ-001 Parameter: LFSR_SEED, 32'h12345678, LFSR value after reset; also substituted for any zero seed.
REQ-002 Parameter: PREVIEW_DEPTH, 3, upcoming pieces visible behind the head; legal range 1..6; queue depth D = PREVIEW_DEPTH+1.
REQ-003 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: take  input  1  consume head piece; one pulse per cycle.
REQ-006 Port: seed_load  input  1  reload LFSR from seed_in and flush queue.
REQ-007 Port: seed_in  input  32  new LFSR seed.
REQ-008 Port: head_valid  output  1  queue holds at least one piece.
REQ-009 Port: head_type  output  3  type code of head piece.
REQ-010 Port: next_block_shape  output  16  4x4 spawn bitmap of head piece; 0 when empty.
REQ-011 Port: preview_shapes  output  16*PREVIEW_DEPTH  entry i (i=0 nearest) at bits [16i+15:16i]; 0 where empty.
REQ-012 Port: queue_full  output  1  count == D.

Function
REQ-013 Type codes/bitmaps SHALL be: 0 O 16'h0660, 1 I 16'h0f00, 2 S 16'h0360, 3 Z 16'h0630, 4 L 16'h0740, 5 J 16'h0e20, 6 T 16'h0720; code 7 never stored.
REQ-014 LFSR SHALL be 32-bit Galois, shift right every cycle not in reset/seed_load; if shifted-out bit is 1, XOR mask 32'h80200003.
REQ-015 Candidate SHALL be lfsr[2:0] of the current cycle.
REQ-016 Generation SHALL occur in any cycle where (count < D) or (take accepted), producing at most one piece per cycle written at queue tail.
REQ-017 take SHALL be accepted only when head_valid=1; take with head_valid=0 SHALL be ignored with no state change.
REQ-018 Accepted take SHALL pop head so entry 0 of preview becomes head next cycle; pop and push in the same cycle SHALL leave count unchanged.
REQ-019 Count SHALL never exceed D nor underflow 0; when count == D and no take, no piece generated and LFSR still advances.
REQ-020 Outputs SHALL be registered: pushed piece visible one cycle after the generating edge.
REQ-021 seed_load SHALL, next cycle, load lfsr with seed_in (LFSR_SEED if seed_in==0), set count 0, clear bag state; take that cycle ignored.
REQ-022 Priority SHALL be rst > seed_load > take/generate.

Reset
REQ-023 On rst=1 at a clock edge: lfsr=LFSR_SEED, count=0, bag cleared, head_valid=0, head_type=0, next_block_shape=0, preview_shapes=0, queue_full=0.
REQ-024 rst asserted mid-fill or mid-take SHALL discard all queued pieces; no partial state survives.

Configuration
REQ-025 Macro SEVEN_BAG_EN defined: 7-bit used-mask; start index = candidate (7 maps to 0); piece = first unused type scanning upward with wrap 6->0; mark used; when all 7 marked after the push, mask clears same edge; a piece SHALL be produced every eligible cycle (fills D entries in exactly D cycles after reset).
REQ-026 Macro SEVEN_BAG_EN undefined: no mask; candidate 0..6 pushed directly; candidate 7 SHALL produce no piece that cycle (retry next cycle); fill latency data-dependent.

Verification
REQ-027 SEVEN_BAG_EN, PREVIEW_DEPTH=3: release rst, take=0 -> queue_full=1 exactly 4 cycles later, 4 distinct head/preview types, no 3'd7.
REQ-028 SEVEN_BAG_EN: take pulsed 14 times after fill -> types 1-7 and 8-14 each a permutation of 0..6.
REQ-029 SEVEN_BAG_EN: take held high 20 cycles after fill -> head_valid=1 and queue_full=1 every cycle, head changes each cycle.
REQ-030 take=1 while head_valid=0 (cycle after reset) -> count stays 0, no pop, LFSR still advances.
REQ-031 seed_load=1, seed_in=0 -> next cycle count=0, outputs 0; subsequent piece sequence identical to post-reset sequence.
REQ-032 rst asserted with count=2 and take=1 -> next cycle all outputs 0; post-release sequence identical to REQ-027.
